sd_block_reader: RTL
====================

SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 16: max polled bytes awaiting R1.
REQ-002 SHALL have parameter TOKEN_TIMEOUT, default 8192: max polled bytes awaiting data token.
REQ-003 SHALL have port clk  input  1  sole clock; one clock domain.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port bus  Wishbone_bus.M  -  master port to the SPI_WB peripheral; classic single cycles.
REQ-006 SHALL have port req_valid  input  1  read request.
REQ-007 SHALL have port req_ready  output  1  high only in IDLE.
REQ-008 SHALL have port req_lba  input  32  sector address; sampled on req_valid&&req_ready.
REQ-009 SHALL have port out_data  output  8  sector byte.
REQ-010 SHALL have port out_valid  output  1  out_data valid; held until out_ready.
REQ-011 SHALL have port out_ready  input  1  consumer accepts byte.
REQ-012 SHALL have port out_last  output  1  marks byte 511.
REQ-013 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse on failure.
REQ-015 SHALL have port err_code  output  2  1=R1 timeout, 2=R1 nonzero, 3=token timeout/bad token; valid with err, held until next request.

Function
REQ-016 SHALL use the SPI_WB map: 0x0 DATA (write starts 8-bit transfer; read returns received byte), 0x1 STATUS (bit0 busy), 0x2 CTRL (bit0 chip-select assert).
REQ-017 SHALL perform each byte exchange as: WB write DATA; poll STATUS until busy=0; WB read DATA.
REQ-018 SHALL hold cyc/stb and fields stable until ack, with one WB cycle in flight at a time.
REQ-019 SHALL sequence states IDLE -> CS_ON (CTRL=1) -> SEND_CMD -> WAIT_R1 -> WAIT_TOKEN -> READ_DATA -> READ_CRC -> CS_OFF (CTRL=0, then one 0xFF byte) -> IDLE.
REQ-020 SHALL, in SEND_CMD, send 6 bytes: 0x51, req_lba[31:24], [23:16], [15:8], [7:0], 0xFF.
REQ-021 SHALL, in WAIT_R1, send 0xFF and accept the first received byte with bit7=0 as R1.
REQ-022 SHALL raise error 1 after RESP_TIMEOUT bytes without R1, and error 2 on R1!=0x00.
REQ-023 SHALL, in WAIT_TOKEN, send 0xFF: 0xFE advances; 0xFF repeats; any other byte or TOKEN_TIMEOUT polls raises error 3.
REQ-024 SHALL read exactly 512 bytes (sending 0xFF), presenting each on out_data with out_valid.
REQ-025 SHALL not start the next byte exchange until the current out byte is accepted (backpressure stalls SPI).
REQ-026 SHALL assert out_last with the 512th byte only, using a 9-bit counter that wraps to 0 after 511.
REQ-027 SHALL read two CRC bytes in READ_CRC and not output them.
REQ-028 SHALL, on any error, go to CS_OFF, then pulse err; done and err SHALL never pulse together.
REQ-029 SHALL pulse done on return to IDLE after success; a req_valid in that same cycle SHALL wait for req_ready next cycle.

Reset
REQ-030 SHALL on rst: state=IDLE, cyc=stb=we=0, out_valid=out_last=done=err=0, err_code=0, counters=0.
REQ-031 SHALL, on rst mid-transfer, abort immediately with no CS_OFF write (SPI_WB is reset by the same rst); out_valid SHALL drop in the cycle after rst.

Configuration
REQ-032 SHALL, with SD_BLOCK_READER_CRC16_EN defined, compute CRC16-CCITT (poly 0x1021, init 0) over the 512 bytes and compare it to the received CRC, a mismatch pulsing err with err_code=3 instead of done.
REQ-033 SHALL, without SD_BLOCK_READER_CRC16_EN, discard the CRC bytes and include no CRC logic.

Structure
REQ-034 SHALL take the SPI_WB register addresses, CTRL/STATUS bit positions, CMD17 opcode, 0xFE token, and the state enum typedef from package sd_pkg.
REQ-035 SHALL implement REQ-017 in sub-module spi_wb_xfer (tx byte, start, rx byte, done).

Verification
REQ-036 SHALL verify: SPI_WB + SD model, lba=0x00000010, R1=0x00 after 2 polls, token after 5 -> MOSI shows 51 00 00 00 10 FF; 512 bytes out; out_last on byte 511; done pulse.
REQ-037 SHALL verify: model never returns R1 -> err, err_code=1 after 16 polls; CTRL ends 0.
REQ-038 SHALL verify: R1=0x04 -> err, err_code=2; no out_valid.
REQ-039 SHALL verify: token byte 0xFC -> err, err_code=3.
REQ-040 SHALL verify: out_ready low 50 cycles at byte 100 -> out_data stable, no SPI activity, all 512 bytes in order.
REQ-041 SHALL verify: rst at byte 200, then new request -> clean full read; with CRC16_EN, a corrupted CRC gives err_code=3.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and state types for the SD single-block reader and its SPI_WB byte engine.
// SD_BLOCK_READER_CRC16_EN enables the CRC16-CCITT helper used for data-block checking.
package sd_pkg;

  localparam logic [3:0] SPI_ADDR_DATA   = 4'h0;
  localparam logic [3:0] SPI_ADDR_STATUS = 4'h1;
  localparam logic [3:0] SPI_ADDR_CTRL   = 4'h2;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned CTRL_CS_BIT     = 0;

  localparam logic [7:0] CMD17_OPCODE = 8'h51;
  localparam logic [7:0] DATA_TOKEN   = 8'hFE;
  localparam logic [7:0] FILL_BYTE    = 8'hFF;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_R1_NONZERO = 2'd2;
  localparam logic [1:0] ERR_TOKEN      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_ON,
    ST_SEND_CMD,
    ST_WAIT_R1,
    ST_WAIT_TOKEN,
    ST_READ_DATA,
    ST_READ_CRC,
    ST_CS_OFF
  } rd_state_e;

  typedef enum logic [2:0] {
    X_IDLE,
    X_CTRL,
    X_WR,
    X_STAT,
    X_RD
  } xfer_state_e;

`ifdef SD_BLOCK_READER_CRC16_EN
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[15] ^ d[7-i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/Wishbone_bus.sv
// Classic single-cycle Wishbone link between the block reader (M) and the SPI_WB peripheral (S).
interface Wishbone_bus;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [3:0] adr;
  logic [7:0] dat_w;
  logic [7:0] dat_r;
  logic       ack;

  modport M (output cyc, stb, we, adr, dat_w, input dat_r, ack);
  modport S (input cyc, stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/spi_wb_xfer.sv
// SPI_WB byte engine: one full-duplex byte (write DATA, poll STATUS, read DATA) or one CTRL write.
// Exactly one Wishbone cycle is outstanding; request fields stay static until ack.
module spi_wb_xfer
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  Wishbone_bus.M     bus,
  input  logic [7:0] tx_i,
  input  logic       start_i,
  input  logic       cs_wr_i,
  input  logic       cs_i,
  output logic [7:0] rx_o,
  output logic       done_o
);

  xfer_state_e st_q, st_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= X_IDLE;
      tx_q   <= '0;
      rx_q   <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    done_d    = 1'b0;
    bus.cyc   = 1'b0;
    bus.stb   = 1'b0;
    bus.we    = 1'b0;
    bus.adr   = SPI_ADDR_DATA;
    bus.dat_w = tx_q;
    case (st_q)
      X_IDLE: begin
        if (cs_wr_i) begin
          tx_d              = '0;
          tx_d[CTRL_CS_BIT] = cs_i;
          st_d              = X_CTRL;
        end else if (start_i) begin
          tx_d = tx_i;
          st_d = X_WR;
        end
      end
      X_CTRL: begin
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b1;
        bus.adr = SPI_ADDR_CTRL;
        if (bus.ack) begin
          done_d = 1'b1;
          st_d   = X_IDLE;
        end
      end
      X_WR: begin
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b1;
        if (bus.ack) st_d = X_STAT;
      end
      X_STAT: begin
        // A busy reply keeps the request up, which starts a fresh STATUS read.
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.adr = SPI_ADDR_STATUS;
        if (bus.ack && !bus.dat_r[STATUS_BUSY_BIT]) st_d = X_RD;
      end
      X_RD: begin
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        if (bus.ack) begin
          rx_d   = bus.dat_r;
          done_d = 1'b1;
          st_d   = X_IDLE;
        end
      end
      default: st_d = X_IDLE;
    endcase
  end

  assign rx_o   = rx_q;
  assign done_o = done_q;

endmodule

// File: rtl/sd_block_reader.sv
// SD card single-block (CMD17) reader over an SPI_WB peripheral, streaming 512 bytes out.
// Define SD_BLOCK_READER_CRC16_EN to check the data CRC16-CCITT; otherwise CRC bytes are discarded.
module sd_block_reader
  import sd_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT  = 16,
  parameter int unsigned TOKEN_TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst,
  Wishbone_bus.M      bus,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_lba,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] RESP_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);

  rd_state_e   state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic        pend_q, pend_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  byte_q, byte_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        fail_q, fail_d;
  logic [1:0]  err_code_q, err_code_d;
`ifdef SD_BLOCK_READER_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_hi_q, crc_hi_d;
`endif

  logic [7:0] x_tx;
  logic       x_start;
  logic       x_cs_wr;
  logic       x_cs;
  logic [7:0] x_rx;
  logic       x_done;

  spi_wb_xfer u_xfer (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tx_i    (x_tx),
    .start_i (x_start),
    .cs_wr_i (x_cs_wr),
    .cs_i    (x_cs),
    .rx_o    (x_rx),
    .done_o  (x_done)
  );

  // The completion-pulse cycle is not an accept slot, so a held request lands one cycle later.
  assign req_ready = (state_q == ST_IDLE) && !done_q && !err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lba_q       <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      byte_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fail_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef SD_BLOCK_READER_CRC16_EN
      crc_q       <= '0;
      crc_hi_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      err_code_q  <= err_code_d;
`ifdef SD_BLOCK_READER_CRC16_EN
      crc_q       <= crc_d;
      crc_hi_q    <= crc_hi_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fail_d      = fail_q;
    err_code_d  = err_code_q;
`ifdef SD_BLOCK_READER_CRC16_EN
    crc_d       = crc_q;
    crc_hi_d    = crc_hi_q;
`endif
    x_tx    = FILL_BYTE;
    x_start = 1'b0;
    x_cs_wr = 1'b0;
    x_cs    = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          lba_d      = req_lba;
          err_code_d = ERR_NONE;
          fail_d     = 1'b0;
          cnt_d      = '0;
          byte_d     = '0;
          pend_d     = 1'b0;
`ifdef SD_BLOCK_READER_CRC16_EN
          crc_d      = '0;
`endif
          state_d    = ST_CS_ON;
        end
      end
      ST_CS_ON: begin
        if (!pend_q) begin
          x_cs_wr = 1'b1;
          x_cs    = 1'b1;
          pend_d  = 1'b1;
        end else if (x_done) begin
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        case (cnt_q[2:0])
          3'd0:    x_tx = CMD17_OPCODE;
          3'd1:    x_tx = lba_q[31:24];
          3'd2:    x_tx = lba_q[23:16];
          3'd3:    x_tx = lba_q[15:8];
          3'd4:    x_tx = lba_q[7:0];
          default: x_tx = FILL_BYTE;
        endcase
        if (!pend_q) begin
          x_start = 1'b1;
          pend_d  = 1'b1;
        end else if (x_done) begin
          pend_d = 1'b0;
          if (cnt_q == 16'd5) begin
            cnt_d   = '0;
            state_d = ST_WAIT_R1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_WAIT_R1: begin
        if (!pend_q) begin
          x_start = 1'b1;
          pend_d  = 1'b1;
        end else if (x_done) begin
          pend_d = 1'b0;
          if (!x_rx[7]) begin
            cnt_d = '0;
            if (x_rx == 8'h00) begin
              state_d = ST_WAIT_TOKEN;
            end else begin
              fail_d     = 1'b1;
              err_code_d = ERR_R1_NONZERO;
              state_d    = ST_CS_OFF;
            end
          end else if (cnt_q == RESP_LAST) begin
            fail_d     = 1'b1;
            err_code_d = ERR_R1_TIMEOUT;
            cnt_d      = '0;
            state_d    = ST_CS_OFF;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_WAIT_TOKEN: begin
        if (!pend_q) begin
          x_start = 1'b1;
          pend_d  = 1'b1;
        end else if (x_done) begin
          pend_d = 1'b0;
          if (x_rx == DATA_TOKEN) begin
            cnt_d   = '0;
            byte_d  = '0;
            state_d = ST_READ_DATA;
          end else if (x_rx != FILL_BYTE || cnt_q == TOKEN_LAST) begin
            fail_d     = 1'b1;
            err_code_d = ERR_TOKEN;
            cnt_d      = '0;
            state_d    = ST_CS_OFF;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_READ_DATA: begin
        // A byte still waiting for the consumer holds off the next SPI exchange.
        if (!pend_q && !out_valid_q) begin
          x_start = 1'b1;
          pend_d  = 1'b1;
        end else if (pend_q && x_done) begin
          pend_d      = 1'b0;
          out_data_d  = x_rx;
          out_valid_d = 1'b1;
          out_last_d  = (byte_q == 9'd511);
          byte_d      = byte_q + 9'd1;
`ifdef SD_BLOCK_READER_CRC16_EN
          crc_d       = crc16_ccitt_byte(crc_q, x_rx);
`endif
          if (byte_q == 9'd511) begin
            cnt_d   = '0;
            state_d = ST_READ_CRC;
          end
        end
      end
      ST_READ_CRC: begin
        if (!pend_q && !out_valid_q) begin
          x_start = 1'b1;
          pend_d  = 1'b1;
        end else if (pend_q && x_done) begin
          pend_d = 1'b0;
          if (cnt_q[0]) begin
            cnt_d   = '0;
            state_d = ST_CS_OFF;
`ifdef SD_BLOCK_READER_CRC16_EN
            if ({crc_hi_q, x_rx} != crc_q) begin
              fail_d     = 1'b1;
              err_code_d = ERR_TOKEN;
            end
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
`ifdef SD_BLOCK_READER_CRC16_EN
            crc_hi_d = x_rx;
`endif
          end
        end
      end
      ST_CS_OFF: begin
        // Phase 0 drops chip-select; phase 1 clocks one trailing fill byte.
        if (!cnt_q[0]) begin
          if (!pend_q) begin
            x_cs_wr = 1'b1;
            x_cs    = 1'b0;
            pend_d  = 1'b1;
          end else if (x_done) begin
            pend_d = 1'b0;
            cnt_d  = 16'd1;
          end
        end else begin
          if (!pend_q) begin
            x_start = 1'b1;
            pend_d  = 1'b1;
          end else if (x_done) begin
            pend_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
            if (fail_q) err_d = 1'b1;
            else        done_d = 1'b1;
            fail_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
